// File: rtl/jpeg_ctrl_pkg.sv
// rtl/jpeg_ctrl_pkg.sv - shared types and defaults for the DCT frame sequencer
package jpeg_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, FILL, STREAM, DRAIN, DONE} seq_state_t;

  localparam int DEF_NUM_WORDS = 32768;
  localparam int DEF_WR_LAT    = 19;
  localparam int DEF_AW        = 15;
  localparam int COL_W         = 4;
endpackage

// File: rtl/dct_frame_sequencer_if.sv
// rtl/dct_frame_sequencer_if.sv - control/address bundle between host, sequencer and DCT datapath
interface dct_frame_sequencer_if
  import jpeg_ctrl_pkg::*;
#(
  parameter int AW = DEF_AW
);
  logic          start;
  logic          hold;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_in_addr;
  logic [AW-1:0] mem_out_addr;
  logic          mem_out_wen;
  logic          tp1_sel;
  logic          tp2_sel;
  logic [2:0]    dct2_row;

  modport master (
    output start, hold,
    input  busy, done, mem_in_addr, mem_out_addr, mem_out_wen, tp1_sel, tp2_sel, dct2_row
  );

  modport slave (
    input  start, hold,
    output busy, done, mem_in_addr, mem_out_addr, mem_out_wen, tp1_sel, tp2_sel, dct2_row
  );
endinterface

// File: rtl/dct_frame_sequencer_tp_pingpong.sv
// rtl/dct_frame_sequencer_tp_pingpong.sv - force/toggle select for one transpose-memory pair
module tp_pingpong
  import jpeg_ctrl_pkg::*;
#(
  parameter logic [COL_W-1:0] FORCE_VAL  = '0,
  parameter logic [2:0]       TOGGLE_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [COL_W-1:0] col,
  output logic             sel
);

  // The force point re-aligns the pair every 16 reads; the toggle fires between force points.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel <= 1'b1;
    end else if (en) begin
      if (col == FORCE_VAL) begin
        sel <= 1'b1;
      end else if (col[2:0] == TOGGLE_VAL) begin
        sel <= !sel;
      end
    end
  end

endmodule

// File: rtl/dct_frame_sequencer.sv
// rtl/dct_frame_sequencer.sv - one-shot frame controller for the two-pass 8x8 DCT datapath
module dct_frame_sequencer
  import jpeg_ctrl_pkg::*;
#(
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int WR_LAT    = DEF_WR_LAT,
  parameter int AW        = DEF_AW
) (
  input logic                   clk,
  input logic                   reset,
  dct_frame_sequencer_if.slave  bus
);

  localparam int            CW        = AW + 1;
  localparam logic [AW-1:0] LAST_WORD = AW'(NUM_WORDS - 1);
  localparam logic [CW-1:0] FILL_LAST = CW'(WR_LAT - 1);
  localparam logic [CW-1:0] CYC_MAX   = '1;

  seq_state_t    state;
  seq_state_t    state_nx;
  logic [AW-1:0] rd_cnt;
  logic [AW-1:0] wr_cnt;
  logic [CW-1:0] cyc;
  logic          reading;
  logic          writing;
  logic          rd_last;
  logic          wr_last;
  logic          in_frame;

  assign rd_last = (rd_cnt == LAST_WORD);
  assign wr_last = (wr_cnt == LAST_WORD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    in_frame = 1'b0;
    reading  = 1'b0;
    writing  = 1'b0;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nx = FILL;
      end
      FILL: begin
        in_frame = 1'b1;
        reading  = !bus.hold;
        if (!bus.hold && cyc == FILL_LAST) state_nx = STREAM;
      end
      STREAM: begin
        in_frame = 1'b1;
        reading  = !bus.hold;
        writing  = !bus.hold;
        if (!bus.hold && rd_last) state_nx = DRAIN;
      end
      DRAIN: begin
        in_frame = 1'b1;
        writing  = !bus.hold;
        if (!bus.hold && wr_last) state_nx = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    bus.busy = in_frame;
  end

  // hold freezes every counter; the write strobe is dropped combinationally so the
  // frozen address is written exactly once, on the first cycle after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
      cyc    <= '0;
    end else if (state == IDLE && bus.start) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
      cyc    <= '0;
    end else if (in_frame && !bus.hold) begin
      if (cyc != CYC_MAX)       cyc    <= cyc + 1'b1;
      if (reading && !rd_last)  rd_cnt <= rd_cnt + 1'b1;
      if (writing && !wr_last)  wr_cnt <= wr_cnt + 1'b1;
    end
  end

  assign bus.mem_in_addr  = rd_cnt;
  assign bus.mem_out_addr = wr_cnt;
  assign bus.mem_out_wen  = !writing;
  assign bus.dct2_row     = rd_cnt[2:0];

  tp_pingpong #(
    .FORCE_VAL  (4'd0),
    .TOGGLE_VAL (3'd0)
  ) u_tp1 (
    .clk   (clk),
    .reset (reset),
    .en    (reading),
    .col   (rd_cnt[COL_W-1:0]),
    .sel   (bus.tp1_sel)
  );

  tp_pingpong #(
    .FORCE_VAL  (4'd9),
    .TOGGLE_VAL (3'd1)
  ) u_tp2 (
    .clk   (clk),
    .reset (reset),
    .en    (reading),
    .col   (rd_cnt[COL_W-1:0]),
    .sel   (bus.tp2_sel)
  );

endmodule

// File: tb/tb_dct_frame_sequencer.sv
// tb/tb_dct_frame_sequencer.sv - self-checking bench for dct_frame_sequencer
module tb_dct_frame_sequencer;
  import jpeg_ctrl_pkg::*;

  localparam int N   = 16;
  localparam int W   = 19;
  localparam int SAW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dct_frame_sequencer_if #(.AW(SAW))    sbus ();
  dct_frame_sequencer_if #(.AW(DEF_AW)) bbus ();

  dct_frame_sequencer #(.NUM_WORDS(N), .WR_LAT(W), .AW(SAW)) u_small (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  dct_frame_sequencer u_big (
    .clk   (clk),
    .reset (reset),
    .bus   (bbus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: p counts non-held cycles since the frame started; outputs follow from p.
  bit m_active = 1'b0;
  int m_p      = 0;
  bit m_t1     = 1'b1;
  bit m_t2     = 1'b1;
  int m_in_idle = 0;
  int m_oa_idle = 0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // select value after the read edges with counter values 0..r have been applied
  function automatic bit sel1(input int r);
    return ((r / 8) % 2) == 0;
  endfunction

  function automatic bit sel2(input int r, input bit init);
    if (r < 1) return init;
    if (r < 9) return !init;
    return (((r - 1) / 8) % 2) == 1;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_active  <= 1'b0;
      m_p       <= 0;
      m_t1      <= 1'b1;
      m_t2      <= 1'b1;
      m_in_idle <= 0;
      m_oa_idle <= 0;
    end else if (m_active) begin
      if (m_p == W + N) begin
        m_active  <= 1'b0;
        m_in_idle <= N - 1;
        m_oa_idle <= N - 1;
        m_t1      <= sel1(N - 1);
        m_t2      <= sel2(N - 1, m_t2);
      end else if (!sbus.hold) begin
        m_p <= m_p + 1;
      end
    end else if (sbus.start) begin
      m_active <= 1'b1;
      m_p      <= 0;
    end
  end

  int e_in, e_oa;
  bit e_wen, e_busy, e_done, e_t1, e_t2;

  always_comb begin
    e_in   = 0;
    e_oa   = 0;
    e_wen  = 1'b1;
    e_busy = 1'b0;
    e_done = 1'b0;
    e_t1   = 1'b1;
    e_t2   = 1'b1;
    if (reset) begin
      if (m_active) begin
        e_in   = imin(m_p, N - 1);
        e_oa   = (m_p < W) ? 0 : imin(m_p - W, N - 1);
        e_wen  = !(m_p >= W && m_p < W + N && !sbus.hold);
        e_busy = (m_p < W + N);
        e_done = (m_p == W + N);
        if (m_p == 0) begin
          e_t1 = m_t1;
          e_t2 = m_t2;
        end else begin
          e_t1 = sel1(imin(m_p - 1, N - 1));
          e_t2 = sel2(imin(m_p - 1, N - 1), m_t2);
        end
      end else begin
        e_in = m_in_idle;
        e_oa = m_oa_idle;
        e_t1 = m_t1;
        e_t2 = m_t2;
      end
    end
  end

  logic [SAW-1:0] wr_log[$];
  int big_wr_n  = 0;
  int big_last  = -1;

  always @(negedge clk) begin
    chk("busy",         sbus.busy,         e_busy);
    chk("done",         sbus.done,         e_done);
    chk("mem_in_addr",  sbus.mem_in_addr,  e_in);
    chk("mem_out_wen",  sbus.mem_out_wen,  e_wen);
    chk("tp1_sel",      sbus.tp1_sel,      e_t1);
    chk("tp2_sel",      sbus.tp2_sel,      e_t2);
    chk("dct2_row",     sbus.dct2_row,     e_in % 8);
    if (!e_wen) chk("mem_out_addr", sbus.mem_out_addr, e_oa);
    if (reset && !sbus.mem_out_wen) wr_log.push_back(sbus.mem_out_addr);
    if (reset && !bbus.mem_out_wen) begin
      chk("big_wr_addr", bbus.mem_out_addr, big_wr_n);
      big_last = int'(bbus.mem_out_addr);
      big_wr_n = big_wr_n + 1;
    end
  end

  logic [SAW-1:0] o_in  [64];
  logic [SAW-1:0] o_oa  [64];
  logic [2:0]     o_row [64];
  logic           o_wen [64];
  logic           o_done[64];
  logic           o_busy[64];
  logic           o_t1  [64];
  logic           o_t2  [64];

  task automatic run_frame(input int ncyc, input int hlo, input int hhi,
                           input int s2a, input int s2b, input int rst_at);
    wr_log.delete();
    @(posedge clk); #1 sbus.start = 1'b1;
    @(posedge clk); #1 sbus.start = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      sbus.hold  = (c >= hlo && c <= hhi);
      sbus.start = (c == s2a || c == s2b);
      if (c == rst_at)     reset = 1'b0;
      if (c == rst_at + 2) reset = 1'b1;
      @(negedge clk);
      o_in[c]   = sbus.mem_in_addr;
      o_oa[c]   = sbus.mem_out_addr;
      o_row[c]  = sbus.dct2_row;
      o_wen[c]  = sbus.mem_out_wen;
      o_done[c] = sbus.done;
      o_busy[c] = sbus.busy;
      o_t1[c]   = sbus.tp1_sel;
      o_t2[c]   = sbus.tp2_sel;
    end
    @(posedge clk); #1;
    sbus.start = 1'b0;
    sbus.hold  = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_write_count"}, wr_log.size(), N);
    for (int i = 0; i < wr_log.size(); i++) chk({tag, "_write_seq"}, wr_log[i], i);
  endtask

  initial begin
    int bc;
    int ndone;
    reset      = 1'b0;
    sbus.start = 1'b0;
    sbus.hold  = 1'b0;
    bbus.start = 1'b0;
    bbus.hold  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wen",  sbus.mem_out_wen, 1);
    chk("rst_tp1",  sbus.tp1_sel, 1);
    chk("rst_tp2",  sbus.tp2_sel, 1);
    chk("rst_addr", sbus.mem_in_addr, 0);
    @(posedge clk); #1 reset = 1'b1;

    // reset lands mid-STREAM at cycle 22
    run_frame(26, -1, -1, -1, -1, 22);
    chk("midrst_wen_before", o_wen[21], 0);
    chk("midrst_wen",  o_wen[22], 1);
    chk("midrst_busy", o_busy[22], 0);
    chk("midrst_tp1",  o_t1[22], 1);
    chk("midrst_tp2",  o_t2[22], 1);

    // clean frame after reset
    run_frame(40, -1, -1, -1, -1, -1);
    chk("in_c0",     o_in[0], 0);
    chk("in_c15",    o_in[15], 15);
    chk("in_c20",    o_in[20], 15);
    chk("wen_c18",   o_wen[18], 1);
    chk("wen_c19",   o_wen[19], 0);
    chk("oa_c19",    o_oa[19], 0);
    chk("oa_c34",    o_oa[34], 15);
    chk("wen_c35",   o_wen[35], 1);
    chk("done_c34",  o_done[34], 0);
    chk("done_c35",  o_done[35], 1);
    chk("busy_c0",   o_busy[0], 1);
    chk("busy_c34",  o_busy[34], 1);
    chk("busy_c35",  o_busy[35], 0);
    chk("tp1_c1",    o_t1[1], 1);
    chk("tp1_c9",    o_t1[9], 0);
    chk("tp2_c2",    o_t2[2], 0);
    chk("tp2_c10",   o_t2[10], 1);
    chk("row_c5",    o_row[5], 5);
    chk("row_c12",   o_row[12], 4);
    check_writes("basic");

    // hold over cycles 21..24
    run_frame(44, 21, 24, -1, -1, -1);
    for (int c = 21; c <= 24; c++) begin
      chk("hold_wen", o_wen[c], 1);
      chk("hold_oa",  o_oa[c], 2);
    end
    chk("hold_wen_c25", o_wen[25], 0);
    chk("hold_oa_c25",  o_oa[25], 2);
    chk("hold_done_c35", o_done[35], 0);
    chk("hold_done_c39", o_done[39], 1);
    check_writes("hold");

    // start pulses while busy and in the DONE cycle
    run_frame(48, -1, -1, 5, 35, -1);
    ndone = 0;
    for (int c = 0; c < 48; c++) ndone += int'(o_done[c]);
    chk("busy_start_done_pulses", ndone, 1);
    chk("busy_start_in_c5",  o_in[6], 6);
    chk("busy_start_idle",   o_busy[40], 0);
    chk("busy_start_idle2",  o_busy[47], 0);
    chk("busy_start_in_end", o_in[47], 15);
    check_writes("busy_start");

    // full-size frame with default parameters
    big_wr_n = 0;
    @(posedge clk); #1 bbus.start = 1'b1;
    @(posedge clk); #1 bbus.start = 1'b0;
    bc = 0;
    while (bc < 40000) begin
      @(negedge clk);
      if (bbus.done) break;
      @(posedge clk); #1;
      bc++;
    end
    chk("big_done_cycle", bc, 32787);
    chk("big_writes",     big_wr_n, 32768);
    chk("big_last_addr",  big_last, 'h7FFF);
    chk("big_in_addr",    bbus.mem_in_addr, 'h7FFF);
    chk("big_busy_done",  bbus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/dct_frame_sequencer.md
Name: dct_frame_sequencer

Overview:
- Start/done controller for the two-pass 8x8 DCT datapath. It drives the MEM_IN read address, the ping-pong selects for both transpose-memory pairs, the second-pass DCT row index, and the MEM_OUT write address and strobe.
- It replaces the free-running counters, so a frame is processed once per start request, with hold and completion signalling.

Parameters:
- NUM_WORDS, 32768, words per frame; must be a multiple of 8 and at least 16.
- WR_LAT, 19, cycles from the first MEM_IN address to the first MEM_OUT write; must be at least 10.
- AW, 15, SRAM address width; 2**AW must be at least NUM_WORDS.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- hold  in  1  freezes all state, counters and outputs while high.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last write.
- mem_in_addr  out  AW  MEM_IN read address; [AW-1:4] is the row field, [3:0] the column field.
- mem_out_addr  out  AW  MEM_OUT write address, same split.
- mem_out_wen  out  1  MEM_OUT write enable, active-low.
- tp1_sel  out  1  first transpose pair select; 1 writes TP1 and reads TP2.
- tp2_sel  out  1  second transpose pair select, same convention.
- dct2_row  out  3  row index for the second-pass DCT.

Behaviour:
- Reset values: busy=0, done=0, mem_in_addr=0, mem_out_addr=0, mem_out_wen=1, tp1_sel=1, tp2_sel=1, dct2_row=0. The FSM enters IDLE. All registers are cleared asynchronously, including mid-frame; no write strobe may be left asserted.
- FSM states: IDLE, FILL, STREAM, DRAIN, DONE.
- IDLE: start=1 moves to FILL on the next edge and loads rd_cnt=0, wr_cnt=0, cyc=0. The mem_in_addr=0 cycle is "cycle 0". hold is ignored in IDLE.
- FILL: rd_cnt increments each cycle and mem_in_addr=rd_cnt. When cyc reaches WR_LAT-1, the FSM moves to STREAM.
- STREAM: reads and writes run concurrently. mem_out_wen=0 and mem_out_addr=wr_cnt, and wr_cnt increments each cycle. rd_cnt saturates at NUM_WORDS-1; once the last read has been issued, the FSM moves to DRAIN.
- DRAIN: writes continue and mem_in_addr holds NUM_WORDS-1. After the write of wr_cnt=NUM_WORDS-1, the FSM moves to DONE with mem_out_wen=1.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. start in the DONE cycle is ignored. start while busy is ignored.
- Write window: writes occur in cycles WR_LAT .. WR_LAT+NUM_WORDS-1. Exactly NUM_WORDS writes are performed, with no address gaps.
- Total frame: done is asserted in cycle WR_LAT+NUM_WORDS.
- tp1_sel (registered, driven by rd_cnt): on an edge where rd_cnt[3:0]==0 it is forced to 1; otherwise, where rd_cnt[2:0]==0, it toggles; otherwise it holds.
- tp2_sel: same rule on rd_cnt, but forced to 1 when rd_cnt[3:0]==9 and toggled when rd_cnt[2:0]==1.
- dct2_row equals rd_cnt[2:0], combinational from the counter register.
- Ping-pong cadence: selects are updated only while the read counter advances, i.e. in FILL and STREAM. They hold in DRAIN, DONE and IDLE.
- hold=1 in FILL, STREAM or DRAIN: all registers freeze, including cyc, rd_cnt, wr_cnt, the selects and the FSM state.
- Write strobe under hold: mem_out_wen is forced to 1 during hold. When hold is released, the same address is written on the next cycle, so no write is duplicated or lost.
- Counter widths: rd_cnt and wr_cnt are AW bits; cyc is AW+1 bits to cover WR_LAT+NUM_WORDS. Counters saturate and never wrap.

Decomposition:
- Shared package jpeg_ctrl_pkg holds:
  - the state enum (IDLE, FILL, STREAM, DRAIN, DONE);
  - the default constants NUM_WORDS=32768, WR_LAT=19 and AW=15;
  - the 4-bit column-field width.
- One natural sub-module, tp_pingpong, generates the force/toggle select for a single pair. It is parameterised by FORCE_VAL (4 bits) and TOGGLE_VAL (3 bits), and instantiated twice: (0,0) for tp1_sel and (9,1) for tp2_sel.
- The FSM and the counters stay in the top module.

Test Plan:
- Reset during STREAM (NUM_WORDS=16, WR_LAT=19), asserted at cycle 22 -> same cycle: mem_out_wen=1, busy=0, both selects=1. After release, a new start runs a full clean frame.
- Basic frame (NUM_WORDS=16, WR_LAT=19, start pulse) ->
  - mem_in_addr steps 0..15 over cycles 0..15;
  - mem_out_wen=0 only in cycles 19..34, with addresses 0..15;
  - done pulses in cycle 35;
  - busy is high over cycles 0..34.
- Ping-pong cadence (same frame) ->
  - tp1_sel=1 after the edge at rd_cnt=0, then toggles at rd_cnt=8;
  - tp2_sel=1 after the edge at rd_cnt=9, toggles at rd_cnt=1;
  - dct2_row tracks rd_cnt[2:0].
- Hold during writes: hold=1 for cycles 21..24 ->
  - wen=1 and all addresses frozen during hold;
  - address 2 is written exactly once, at cycle 25;
  - done is delayed by 4 cycles, to cycle 39.
- Start while busy (pulse start at cycle 5 and in the DONE cycle) -> both ignored; no second frame begins and the counters are unaffected.
- Full-size frame (defaults) -> exactly 32768 writes, last address 0x7FFF, done in cycle 32787, no counter wrap.
